// File: rtl/reg_arb_pkg.sv
// Shared types and reset/default constants for the register access arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam int MIN_REQ          = 2;
    localparam int MAX_REQ          = 8;
    localparam int RST_PTR          = 0;
    localparam int DEF_TIMEOUT      = 255;
    localparam logic RST_BUSY       = 1'b0;

    function automatic int idx_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Requester-side bus of the register access arbiter: request fields in, ack/read-return out.
interface reg_access_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]                 i_req;
    logic [N_REQ-1:0]                 i_we;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] i_addr;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] i_wdata;
    logic [N_REQ-1:0]                 o_ack;
    logic [N_REQ-1:0]                 o_rvalid;
    logic [DATA_WIDTH-1:0]            o_rdata;
    logic                             o_rerr;

    // Arbiter side.
    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output o_ack, o_rvalid, o_rdata, o_rerr
    );

    // Requester side.
    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  o_ack, o_rvalid, o_rdata, o_rerr
    );
endinterface

// File: rtl/reg_access_arbiter_rr_arbiter.sv
// Round-robin grant selection: first active request at or after ptr, one-hot result.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter serialising N_REQ requesters onto one register block port.
// Optional read timeout enabled by defining REG_ARB_TIMEOUT_EN.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  i_reset,
    reg_access_arbiter_if.slave   bus,
    output logic                  o_w_en,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [DATA_WIDTH-1:0] o_w_value,
    output logic                  o_r_en,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    input  logic [DATA_WIDTH-1:0] i_r_value,
    input  logic                  i_r_valid,
    output logic                  o_busy
);

    localparam int IDX_W = idx_width(N_REQ);

    state_t                  state;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        cur;
    logic [IDX_W-1:0]        grant_idx;
    logic [N_REQ-1:0]        grant_oh;
    logic                    cap_we;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (bus.i_req),
        .ptr   (ptr),
        .grant (grant_oh)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) grant_idx = IDX_W'(i);
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt;
`else
    localparam int unused_timeout_cfg = TIMEOUT_CYCLES;
    assign bus.o_rerr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state        <= IDLE;
            ptr          <= IDX_W'(RST_PTR);
            cur          <= '0;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            bus.o_ack    <= '0;
            bus.o_rvalid <= '0;
            bus.o_rdata  <= '0;
            o_w_en       <= 1'b0;
            o_w_addr     <= '0;
            o_w_value    <= '0;
            o_r_en       <= 1'b0;
            o_r_addr     <= '0;
            o_busy       <= RST_BUSY;
`ifdef REG_ARB_TIMEOUT_EN
            bus.o_rerr   <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            bus.o_ack    <= '0;
            bus.o_rvalid <= '0;
            o_w_en       <= 1'b0;
            o_r_en       <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.i_req) begin
                        cur       <= grant_idx;
                        cap_we    <= bus.i_we[grant_idx];
                        cap_addr  <= bus.i_addr[grant_idx];
                        cap_wdata <= bus.i_wdata[grant_idx];
                        ptr       <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state     <= ISSUE;
                        o_busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    bus.o_ack[cur] <= 1'b1;
                    if (cap_we) begin
                        o_w_en    <= 1'b1;
                        o_w_addr  <= cap_addr;
                        o_w_value <= cap_wdata;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                    end else begin
                        o_r_en    <= 1'b1;
                        o_r_addr  <= cap_addr;
                        state     <= WAIT_RD;
`ifdef REG_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                WAIT_RD: begin
                    if (i_r_valid) begin
                        bus.o_rdata       <= i_r_value;
                        bus.o_rvalid[cur] <= 1'b1;
                        state             <= IDLE;
                        o_busy            <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
                        bus.o_rerr        <= 1'b0;
                    end else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        bus.o_rdata       <= '0;
                        bus.o_rvalid[cur] <= 1'b1;
                        bus.o_rerr        <= 1'b1;
                        state             <= IDLE;
                        o_busy            <= 1'b0;
                    end else begin
                        wait_cnt          <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed self-checking bench for reg_access_arbiter (N_REQ=2, TIMEOUT_CYCLES=4).
module tb_reg_access_arbiter;

    localparam int N_REQ = 2;
    localparam int AW    = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          o_w_en, o_r_en, o_busy, i_r_valid;
    logic [AW-1:0] o_w_addr, o_r_addr;
    logic [DW-1:0] o_w_value, i_r_value;

    int n_cmp = 0;
    int n_err = 0;

    reg_access_arbiter_if #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_access_arbiter #(
        .N_REQ          (N_REQ),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .i_reset   (i_reset),
        .bus       (bus),
        .o_w_en    (o_w_en),
        .o_w_addr  (o_w_addr),
        .o_w_value (o_w_value),
        .o_r_en    (o_r_en),
        .o_r_addr  (o_r_addr),
        .i_r_value (i_r_value),
        .i_r_valid (i_r_valid),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset     = 1'b0;
        i_r_valid   = 1'b0;
        i_r_value   = '0;
        bus.i_req   = '0;
        bus.i_we    = '0;
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        #2;
        do_reset();

        check("rst_busy",   64'(o_busy), 64'd0);
        check("rst_ack",    64'(bus.o_ack), 64'd0);
        check("rst_rvalid", 64'(bus.o_rvalid), 64'd0);
        check("rst_wen",    64'(o_w_en), 64'd0);
        check("rst_ren",    64'(o_r_en), 64'd0);
        check("rst_rdata",  64'(bus.o_rdata), 64'd0);
        check("rst_rerr",   64'(bus.o_rerr), 64'd0);

        // Single write from requester 0
        bus.i_req      = 2'b01;
        bus.i_we       = 2'b01;
        bus.i_addr[0]  = 8'h03;
        bus.i_wdata[0] = 32'hDEADBEEF;
        tick();
        check("wr_busy1", 64'(o_busy), 64'd1);
        check("wr_wen1",  64'(o_w_en), 64'd0);
        tick();
        check("wr_wen2",  64'(o_w_en), 64'd1);
        check("wr_addr",  64'(o_w_addr), 64'h03);
        check("wr_data",  64'(o_w_value), 64'hDEADBEEF);
        check("wr_ack",   64'(bus.o_ack), 64'b01);
        check("wr_ren",   64'(o_r_en), 64'd0);
        bus.i_req = '0;
        tick();
        check("wr_wen3",  64'(o_w_en), 64'd0);
        check("wr_ack3",  64'(bus.o_ack), 64'd0);
        check("wr_busy3", 64'(o_busy), 64'd0);

        // Round-robin alternation after reset
        do_reset();
        bus.i_req      = 2'b11;
        bus.i_we       = 2'b11;
        bus.i_addr[0]  = 8'h10;
        bus.i_addr[1]  = 8'h11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gap_ack", 64'(bus.o_ack), 64'd0);
            tick();
            check("rr_ack",  64'(bus.o_ack), (k % 2 == 0) ? 64'b01 : 64'b10);
            check("rr_addr", 64'(o_w_addr), (k % 2 == 0) ? 64'h10 : 64'h11);
        end
        bus.i_req = '0;
        tick();
        tick();

        // Stray read-valid while idle is ignored
        i_r_valid = 1'b1;
        i_r_value = 32'hCAFEF00D;
        tick();
        i_r_valid = 1'b0;
        tick();
        check("idle_rv_ignored", 64'(bus.o_rvalid), 64'd0);
        check("idle_rdata_hold", 64'(bus.o_rdata), 64'd0);

        // Read from requester 1, data returned 3 cycles after o_r_en
        bus.i_req     = 2'b10;
        bus.i_we      = 2'b00;
        bus.i_addr[1] = 8'h05;
        tick();
        tick();
        check("rd_ren",   64'(o_r_en), 64'd1);
        check("rd_raddr", 64'(o_r_addr), 64'h05);
        check("rd_ack",   64'(bus.o_ack), 64'b10);
        bus.i_req = '0;
        tick();
        check("rd_ren_low", 64'(o_r_en), 64'd0);
        tick();
        check("rd_wait_busy", 64'(o_busy), 64'd1);
        check("rd_wait_rv",   64'(bus.o_rvalid), 64'd0);
        i_r_valid = 1'b1;
        i_r_value = 32'h12345678;
        tick();
        i_r_valid = 1'b0;
        check("rd_rvalid", 64'(bus.o_rvalid), 64'b10);
        check("rd_rdata",  64'(bus.o_rdata), 64'h12345678);
        check("rd_rerr",   64'(bus.o_rerr), 64'd0);
        tick();
        check("rd_rvalid_low", 64'(bus.o_rvalid), 64'd0);
        check("rd_rdata_hold", 64'(bus.o_rdata), 64'h12345678);
        check("rd_busy_end",   64'(o_busy), 64'd0);

        // Reset during WAIT_RD followed by a late read-valid
        bus.i_req     = 2'b01;
        bus.i_we      = 2'b00;
        bus.i_addr[0] = 8'h07;
        tick();
        tick();
        check("rst_rd_ren", 64'(o_r_en), 64'd1);
        bus.i_req = '0;
        tick();
        i_reset = 1'b1;
        tick();
        i_reset   = 1'b0;
        i_r_valid = 1'b1;
        i_r_value = 32'hAAAA5555;
        tick();
        i_r_valid = 1'b0;
        check("rst_rd_rv",    64'(bus.o_rvalid), 64'd0);
        check("rst_rd_busy",  64'(o_busy), 64'd0);
        tick();
        check("rst_rd_rv2",   64'(bus.o_rvalid), 64'd0);
        check("rst_rd_rdata", 64'(bus.o_rdata), 64'd0);

        // Lone requester 1 granted twice in a row
        bus.i_req      = 2'b10;
        bus.i_we       = 2'b10;
        bus.i_addr[1]  = 8'h22;
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
            check("solo_ack", 64'(bus.o_ack), 64'b10);
        end
        bus.i_req = '0;
        tick();
        tick();

        // Read with no response
        bus.i_req     = 2'b01;
        bus.i_we      = 2'b00;
        bus.i_addr[0] = 8'h09;
        tick();
        tick();
        check("to_ren", 64'(o_r_en), 64'd1);
        bus.i_req = '0;
        tick();
        tick();
        tick();
        check("to_pre_rv", 64'(bus.o_rvalid), 64'd0);
        tick();
`ifdef REG_ARB_TIMEOUT_EN
        check("to_rvalid", 64'(bus.o_rvalid), 64'b01);
        check("to_rerr",   64'(bus.o_rerr), 64'd1);
        check("to_rdata",  64'(bus.o_rdata), 64'd0);
        tick();
        check("to_busy",   64'(o_busy), 64'd0);
`else
        check("nto_rvalid", 64'(bus.o_rvalid), 64'd0);
        check("nto_busy",   64'(o_busy), 64'd1);
        for (int k = 0; k < 10; k++) tick();
        check("nto_busy_long", 64'(o_busy), 64'd1);
        i_r_valid = 1'b1;
        i_r_value = 32'h0BADC0DE;
        tick();
        i_r_valid = 1'b0;
        check("nto_rvalid_end", 64'(bus.o_rvalid), 64'b01);
        check("nto_rdata",      64'(bus.o_rdata), 64'h0BADC0DE);
        check("nto_rerr",       64'(bus.o_rerr), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
